// File: rtl/ccip_protocol_tracker_pkg.sv
// Shared types for the CCI-P protocol tracker: header layouts, error codes,
// CL length encodings and framing FSM states.
package ccip_protocol_tracker_pkg;

    typedef enum logic [3:0] {
        ErrNone           = 4'd0,
        ErrIllegalLen     = 4'd1,
        ErrSopMissing     = 4'd2,
        ErrSopUnexpected  = 4'd3,
        ErrHdrChanged     = 4'd4,
        ErrRdTagReuse     = 4'd5,
        ErrRdOrphanRsp    = 4'd6,
        ErrWrTagReuse     = 4'd7,
        ErrWrOrphanRsp    = 4'd8,
        ErrRdTimeout      = 4'd9,
        ErrWrTimeout      = 4'd10,
        ErrAlmfullOverrun = 4'd11
    } ccip_chk_err_e;

    localparam logic [1:0] ASE_1CL = 2'd0;
    localparam logic [1:0] ASE_2CL = 2'd1;
    localparam logic [1:0] ASE_3CL = 2'd2;
    localparam logic [1:0] ASE_4CL = 2'd3;

    typedef struct packed {
        logic [1:0]  vc;
        logic        sop;
        logic [1:0]  len;
        logic [3:0]  req_type;
        logic [41:0] addr;
        logic [15:0] mdata;
    } TxHdr_t;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        hit_miss;
        logic        format;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } RxHdr_t;

    typedef enum logic {StIdle, StInPkt} frame_state_e;

    function automatic logic len_legal(input logic [1:0] len);
        return len != ASE_3CL;
    endfunction

endpackage

// File: rtl/ccip_tag_tracker.sv
// Per-tag outstanding-request table: detects tag reuse, orphan responses and
// response timeouts, and keeps a count of pending tags.
module ccip_tag_tracker #(
    parameter int unsigned TAG_W          = 6,
    parameter int unsigned AGE_W          = 13,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter bit          PACKED_EN      = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_issue_valid,
    input  logic [TAG_W-1:0] i_issue_tag,
    input  logic [1:0]       i_issue_len,
    input  logic             i_rsp_valid,
    input  logic [TAG_W-1:0] i_rsp_tag,
    input  logic             i_rsp_packed,
    output logic             o_reuse,
    output logic [TAG_W-1:0] o_reuse_tag,
    output logic             o_orphan,
    output logic [TAG_W-1:0] o_orphan_tag,
    output logic             o_timeout,
    output logic [TAG_W-1:0] o_timeout_tag,
    output logic [TAG_W:0]   o_count
);

    localparam int unsigned      Depth  = 1 << TAG_W;
    localparam logic [AGE_W-1:0] AgeMax = AGE_W'(TIMEOUT_CYCLES - 1);

    logic [Depth-1:0] r_pending, w_pending_d;
    logic [Depth-1:0] r_timed_out, w_timed_out_d;
    logic [1:0]       r_remaining [Depth];
    logic [1:0]       w_remaining_d [Depth];
    logic [AGE_W-1:0] r_age [Depth];
    logic [AGE_W-1:0] w_age_d [Depth];
    logic [TAG_W:0]   r_count;

    logic w_rsp_hit, w_rsp_free, w_issue_busy, w_alloc;

    always_comb begin
        w_rsp_hit    = i_rsp_valid && r_pending[i_rsp_tag];
        w_rsp_free   = w_rsp_hit && ((PACKED_EN && i_rsp_packed) || r_remaining[i_rsp_tag] == 2'd0);
        // A response freeing the same tag this cycle makes the issue legal.
        w_issue_busy = r_pending[i_issue_tag] && !(w_rsp_free && i_rsp_tag == i_issue_tag);
        w_alloc      = i_issue_valid && !w_issue_busy;
        o_reuse      = i_issue_valid && w_issue_busy;
        o_reuse_tag  = i_issue_tag;
        o_orphan     = i_rsp_valid && !r_pending[i_rsp_tag];
        o_orphan_tag = i_rsp_tag;
    end

    always_comb begin
        w_pending_d   = r_pending;
        w_timed_out_d = r_timed_out;
        w_remaining_d = r_remaining;
        w_age_d       = r_age;
        o_timeout     = 1'b0;
        o_timeout_tag = '0;
        for (int i = int'(Depth) - 1; i >= 0; i--) begin
            if (r_pending[i] && !r_timed_out[i]) begin
                if (r_age[i] == AgeMax) begin
                    w_timed_out_d[i] = 1'b1;
                    o_timeout        = 1'b1;
                    o_timeout_tag    = TAG_W'(i);
                end else begin
                    w_age_d[i] = r_age[i] + AGE_W'(1);
                end
            end
        end
        if (w_rsp_hit) begin
            if (w_rsp_free) begin
                w_pending_d[i_rsp_tag]   = 1'b0;
                w_timed_out_d[i_rsp_tag] = 1'b0;
            end else begin
                w_remaining_d[i_rsp_tag] = r_remaining[i_rsp_tag] - 2'd1;
            end
        end
        if (w_alloc) begin
            w_pending_d[i_issue_tag]   = 1'b1;
            w_timed_out_d[i_issue_tag] = 1'b0;
            w_remaining_d[i_issue_tag] = i_issue_len;
            w_age_d[i_issue_tag]       = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending   <= '0;
            r_timed_out <= '0;
            r_remaining <= '{default: '0};
            r_age       <= '{default: '0};
            r_count     <= '0;
        end else begin
            r_pending   <= w_pending_d;
            r_timed_out <= w_timed_out_d;
            r_remaining <= w_remaining_d;
            r_age       <= w_age_d;
            r_count     <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_rsp_free);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ccip_protocol_tracker.sv
// CCI-P protocol checker beside the AFU port: write framing, tag tracking and
// almost-full discipline, reported as a registered error stream plus sticky flags.
module ccip_protocol_tracker
    import ccip_protocol_tracker_pkg::*;
#(
    parameter int unsigned TAG_W          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned AGE_W          = 13,
    parameter int unsigned ALMFULL_SLACK  = 8
) (
    input  logic             clk,
    input  logic             SoftReset_n,
    input  TxHdr_t           C0TxHdr,
    input  logic             C0TxRdValid,
    input  TxHdr_t           C1TxHdr,
    input  logic             C1TxWrValid,
    input  RxHdr_t           C0RxHdr,
    input  logic             C0RxRdValid,
    input  RxHdr_t           C1RxHdr,
    input  logic             C1RxWrValid,
    input  logic             C0TxAlmFull,
    input  logic             C1TxAlmFull,
    output logic             err_valid,
    output logic [3:0]       err_code,
    output logic [TAG_W-1:0] err_tag,
    output logic [15:0]      err_sticky,
    output logic [TAG_W:0]   rd_outstanding,
    output logic [TAG_W:0]   wr_outstanding
);

    localparam int unsigned      AfW     = $clog2(ALMFULL_SLACK + 2);
    localparam logic [AfW-1:0]   AfSlack = AfW'(ALMFULL_SLACK);

    frame_state_e r_state, w_state_d;
    logic [1:0]   r_beats_left, w_beats_d;
    logic [1:0]   r_len, w_len_d;
    logic [1:0]   r_vc, w_vc_d;
    logic [AfW-1:0] r_af0, r_af1;

    logic             r_err_valid;
    ccip_chk_err_e    r_err_code, w_code;
    logic [TAG_W-1:0] r_err_tag, w_tag;
    logic [15:0]      r_sticky, w_err;

    logic w_c0_ill, w_c1_ill, w_rd_issue, w_wr_issue;
    logic w_sop_missing, w_sop_unexp, w_hdr_chg;
    logic w_af0_req, w_af1_req, w_af0_over, w_af1_over;

    logic             w_rd_reuse, w_rd_orphan, w_rd_timeout;
    logic             w_wr_reuse, w_wr_orphan, w_wr_timeout;
    logic [TAG_W-1:0] w_rd_reuse_tag, w_rd_orphan_tag, w_rd_timeout_tag;
    logic [TAG_W-1:0] w_wr_reuse_tag, w_wr_orphan_tag, w_wr_timeout_tag;

    logic w_unused;
    assign w_unused = ^{C0TxHdr, C1TxHdr, C0RxHdr, C1RxHdr};

    assign w_c0_ill   = C0TxRdValid && !len_legal(C0TxHdr.len);
    assign w_c1_ill   = C1TxWrValid && !len_legal(C1TxHdr.len);
    assign w_rd_issue = C0TxRdValid && !w_c0_ill;

    always_comb begin
        w_state_d     = r_state;
        w_beats_d     = r_beats_left;
        w_len_d       = r_len;
        w_vc_d        = r_vc;
        w_sop_missing = 1'b0;
        w_sop_unexp   = 1'b0;
        w_hdr_chg     = 1'b0;
        w_wr_issue    = 1'b0;
        if (C1TxWrValid) begin
            if (r_state == StInPkt && !C1TxHdr.sop) begin
                w_hdr_chg = (C1TxHdr.len != r_len) || (C1TxHdr.vc != r_vc);
                w_beats_d = r_beats_left - 2'd1;
                if (r_beats_left == 2'd1) w_state_d = StIdle;
            end else begin
                // SOP beat in either state restarts the packet; a non-SOP in
                // IDLE is treated as a standalone 1CL beat.
                w_sop_unexp   = r_state == StInPkt;
                w_sop_missing = r_state == StIdle && !C1TxHdr.sop;
                if (C1TxHdr.sop && !w_c1_ill) begin
                    w_wr_issue = 1'b1;
                    w_len_d    = C1TxHdr.len;
                    w_vc_d     = C1TxHdr.vc;
                    w_beats_d  = C1TxHdr.len;
                    w_state_d  = (C1TxHdr.len != ASE_1CL) ? StInPkt : StIdle;
                end else begin
                    w_beats_d = '0;
                    w_state_d = StIdle;
                end
            end
        end
    end

    assign w_af0_req  = C0TxRdValid;
    assign w_af1_req  = C1TxWrValid && C1TxHdr.sop;
    assign w_af0_over = C0TxAlmFull && w_af0_req && (r_af0 >= AfSlack);
    assign w_af1_over = C1TxAlmFull && w_af1_req && (r_af1 >= AfSlack);

    ccip_tag_tracker #(
        .TAG_W          (TAG_W),
        .AGE_W          (AGE_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .PACKED_EN      (1'b0)
    ) u_rd_tracker (
        .i_clk         (clk),
        .i_rst_n       (SoftReset_n),
        .i_issue_valid (w_rd_issue),
        .i_issue_tag   (C0TxHdr.mdata[TAG_W-1:0]),
        .i_issue_len   (C0TxHdr.len),
        .i_rsp_valid   (C0RxRdValid),
        .i_rsp_tag     (C0RxHdr.mdata[TAG_W-1:0]),
        .i_rsp_packed  (C0RxHdr.format),
        .o_reuse       (w_rd_reuse),
        .o_reuse_tag   (w_rd_reuse_tag),
        .o_orphan      (w_rd_orphan),
        .o_orphan_tag  (w_rd_orphan_tag),
        .o_timeout     (w_rd_timeout),
        .o_timeout_tag (w_rd_timeout_tag),
        .o_count       (rd_outstanding)
    );

    ccip_tag_tracker #(
        .TAG_W          (TAG_W),
        .AGE_W          (AGE_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .PACKED_EN      (1'b1)
    ) u_wr_tracker (
        .i_clk         (clk),
        .i_rst_n       (SoftReset_n),
        .i_issue_valid (w_wr_issue),
        .i_issue_tag   (C1TxHdr.mdata[TAG_W-1:0]),
        .i_issue_len   (C1TxHdr.len),
        .i_rsp_valid   (C1RxWrValid),
        .i_rsp_tag     (C1RxHdr.mdata[TAG_W-1:0]),
        .i_rsp_packed  (C1RxHdr.format),
        .o_reuse       (w_wr_reuse),
        .o_reuse_tag   (w_wr_reuse_tag),
        .o_orphan      (w_wr_orphan),
        .o_orphan_tag  (w_wr_orphan_tag),
        .o_timeout     (w_wr_timeout),
        .o_timeout_tag (w_wr_timeout_tag),
        .o_count       (wr_outstanding)
    );

    always_comb begin
        w_err                    = '0;
        w_err[ErrIllegalLen]     = w_c0_ill || w_c1_ill;
        w_err[ErrSopMissing]     = w_sop_missing;
        w_err[ErrSopUnexpected]  = w_sop_unexp;
        w_err[ErrHdrChanged]     = w_hdr_chg;
        w_err[ErrRdTagReuse]     = w_rd_reuse;
        w_err[ErrRdOrphanRsp]    = w_rd_orphan;
        w_err[ErrWrTagReuse]     = w_wr_reuse;
        w_err[ErrWrOrphanRsp]    = w_wr_orphan;
        w_err[ErrRdTimeout]      = w_rd_timeout;
        w_err[ErrWrTimeout]      = w_wr_timeout;
        w_err[ErrAlmfullOverrun] = w_af0_over || w_af1_over;
        w_code = ErrNone;
        for (int i = 15; i >= 1; i--) begin
            if (w_err[i]) w_code = ccip_chk_err_e'(4'(i));
        end
        case (w_code)
            ErrRdTagReuse:  w_tag = w_rd_reuse_tag;
            ErrRdOrphanRsp: w_tag = w_rd_orphan_tag;
            ErrWrTagReuse:  w_tag = w_wr_reuse_tag;
            ErrWrOrphanRsp: w_tag = w_wr_orphan_tag;
            ErrRdTimeout:   w_tag = w_rd_timeout_tag;
            ErrWrTimeout:   w_tag = w_wr_timeout_tag;
            default:        w_tag = '0;
        endcase
    end

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_state      <= StIdle;
            r_beats_left <= '0;
            r_len        <= '0;
            r_vc         <= '0;
            r_af0        <= '0;
            r_af1        <= '0;
            r_err_valid  <= 1'b0;
            r_err_code   <= ErrNone;
            r_err_tag    <= '0;
            r_sticky     <= '0;
        end else begin
            r_state      <= w_state_d;
            r_beats_left <= w_beats_d;
            r_len        <= w_len_d;
            r_vc         <= w_vc_d;
            // Counters saturate one above the slack so every further request overruns.
            if (!C0TxAlmFull)                     r_af0 <= '0;
            else if (w_af0_req && r_af0 <= AfSlack) r_af0 <= r_af0 + AfW'(1);
            if (!C1TxAlmFull)                     r_af1 <= '0;
            else if (w_af1_req && r_af1 <= AfSlack) r_af1 <= r_af1 + AfW'(1);
            r_err_valid  <= |w_err;
            r_err_code   <= w_code;
            r_err_tag    <= w_tag;
            r_sticky     <= r_sticky | w_err;
        end
    end

    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign err_tag    = r_err_tag;
    assign err_sticky = r_sticky;

endmodule

// File: tb/tb_ccip_protocol_tracker.sv
// Scoreboard bench for ccip_protocol_tracker: expected errors are queued as
// stimulus is driven and matched against the registered error stream.
module tb_ccip_protocol_tracker;
    import ccip_protocol_tracker_pkg::*;

    localparam int unsigned TAG_W = 6;
    localparam int unsigned TMO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    TxHdr_t c0_tx_hdr, c1_tx_hdr;
    RxHdr_t c0_rx_hdr, c1_rx_hdr;
    logic c0_tx_valid, c1_tx_valid, c0_rx_valid, c1_rx_valid;
    logic c0_almfull, c1_almfull;

    logic             err_valid;
    logic [3:0]       err_code;
    logic [TAG_W-1:0] err_tag;
    logic [15:0]      err_sticky;
    logic [TAG_W:0]   rd_outstanding, wr_outstanding;

    int checks = 0;
    int errors = 0;
    logic [3:0]       exp_code_q [$];
    logic [TAG_W-1:0] exp_tag_q [$];
    logic [15:0]      exp_sticky = '0;
    logic [3:0]       m_code;
    logic [TAG_W-1:0] m_tag;

    ccip_protocol_tracker #(
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TMO),
        .AGE_W          (13),
        .ALMFULL_SLACK  (8)
    ) dut (
        .clk            (clk),
        .SoftReset_n    (rst_n),
        .C0TxHdr        (c0_tx_hdr),
        .C0TxRdValid    (c0_tx_valid),
        .C1TxHdr        (c1_tx_hdr),
        .C1TxWrValid    (c1_tx_valid),
        .C0RxHdr        (c0_rx_hdr),
        .C0RxRdValid    (c0_rx_valid),
        .C1RxHdr        (c1_rx_hdr),
        .C1RxWrValid    (c1_rx_valid),
        .C0TxAlmFull    (c0_almfull),
        .C1TxAlmFull    (c1_almfull),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .err_tag        (err_tag),
        .err_sticky     (err_sticky),
        .rd_outstanding (rd_outstanding),
        .wr_outstanding (wr_outstanding)
    );

    // Scoreboard consumer: every reported error must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && err_valid) begin
            checks++;
            if (exp_code_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_err: got code=%0d tag=%0d, required no error",
                         err_code, err_tag);
            end else begin
                m_code = exp_code_q.pop_front();
                m_tag  = exp_tag_q.pop_front();
                if (err_code !== m_code || err_tag !== m_tag) begin
                    errors++;
                    $display("FAIL err_stream: got code=%0d tag=%0d, required code=%0d tag=%0d",
                             err_code, err_tag, m_code, m_tag);
                end
            end
        end
    end

    task automatic clear_inputs();
        c0_tx_hdr = '0; c1_tx_hdr = '0; c0_rx_hdr = '0; c1_rx_hdr = '0;
        c0_tx_valid = 1'b0; c1_tx_valid = 1'b0; c0_rx_valid = 1'b0; c1_rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic rd_req(input int tag, input logic [1:0] len);
        c0_tx_hdr.mdata = 16'(tag);
        c0_tx_hdr.len   = len;
        c0_tx_valid     = 1'b1;
    endtask

    task automatic wr_beat(input logic sop, input logic [1:0] len, input logic [1:0] vc,
                           input int tag);
        c1_tx_hdr.sop   = sop;
        c1_tx_hdr.len   = len;
        c1_tx_hdr.vc    = vc;
        c1_tx_hdr.mdata = 16'(tag);
        c1_tx_valid     = 1'b1;
    endtask

    task automatic rd_rsp(input int tag);
        c0_rx_hdr.mdata = 16'(tag);
        c0_rx_valid     = 1'b1;
    endtask

    task automatic wr_rsp(input int tag, input logic fmt);
        c1_rx_hdr.mdata  = 16'(tag);
        c1_rx_hdr.format = fmt;
        c1_rx_valid      = 1'b1;
    endtask

    task automatic expect_err(input int code, input int tag);
        exp_code_q.push_back(4'(code));
        exp_tag_q.push_back(TAG_W'(tag));
        exp_sticky[code] = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (err_valid !== 1'b0 || err_sticky !== 16'h0) begin
            errors++;
            $display("FAIL reset_err: got valid=%0b sticky=%h, required 0/0000", err_valid, err_sticky);
        end
        checks++;
        if (rd_outstanding !== '0 || wr_outstanding !== '0) begin
            errors++;
            $display("FAIL reset_counts: got rd=%0d wr=%0d, required 0/0", rd_outstanding, wr_outstanding);
        end
    endtask

    task automatic test_write_4cl();
        wr_beat(1'b1, ASE_4CL, 2'd0, 12); tick();
        checks++;
        if (wr_outstanding !== 7'd1) begin
            errors++; $display("FAIL wr4_alloc: got %0d, required 1", wr_outstanding);
        end
        for (int i = 0; i < 3; i++) begin
            wr_beat(1'b0, ASE_4CL, 2'd0, 12); tick();
        end
        checks++;
        if (wr_outstanding !== 7'd1) begin
            errors++; $display("FAIL wr4_done: got %0d, required 1", wr_outstanding);
        end
        wr_rsp(12, 1'b1); tick();
        checks++;
        if (wr_outstanding !== 7'd0) begin
            errors++; $display("FAIL wr4_packed_free: got %0d, required 0", wr_outstanding);
        end
    endtask

    task automatic test_framing();
        wr_beat(1'b0, ASE_1CL, 2'd0, 0); expect_err(2, 0); tick();
        checks++;
        if (wr_outstanding !== 7'd0) begin
            errors++; $display("FAIL sop_missing_noalloc: got %0d, required 0", wr_outstanding);
        end
        wr_beat(1'b1, ASE_2CL, 2'd0, 30); tick();
        wr_beat(1'b1, ASE_2CL, 2'd0, 31); expect_err(3, 0); tick();
        wr_beat(1'b0, ASE_2CL, 2'd0, 31); tick();
        checks++;
        if (wr_outstanding !== 7'd2) begin
            errors++; $display("FAIL sop_unexp_restart: got %0d, required 2", wr_outstanding);
        end
        wr_rsp(30, 1'b1); tick();
        wr_rsp(31, 1'b1); tick();
        wr_beat(1'b1, ASE_2CL, 2'd0, 32); tick();
        wr_beat(1'b0, ASE_2CL, 2'd1, 32); expect_err(4, 0); tick();
        wr_rsp(32, 1'b0); tick();
        checks++;
        if (wr_outstanding !== 7'd1) begin
            errors++; $display("FAIL wr_unpacked_first: got %0d, required 1", wr_outstanding);
        end
        wr_rsp(32, 1'b0); tick();
        checks++;
        if (wr_outstanding !== 7'd0) begin
            errors++; $display("FAIL wr_unpacked_last: got %0d, required 0", wr_outstanding);
        end
    endtask

    task automatic test_read_lifecycle();
        rd_req(5, ASE_2CL); tick();
        checks++;
        if (rd_outstanding !== 7'd1) begin
            errors++; $display("FAIL rd5_issue: got %0d, required 1", rd_outstanding);
        end
        rd_rsp(5); tick();
        checks++;
        if (rd_outstanding !== 7'd1) begin
            errors++; $display("FAIL rd5_rsp1: got %0d, required 1", rd_outstanding);
        end
        rd_rsp(5); tick();
        checks++;
        if (rd_outstanding !== 7'd0) begin
            errors++; $display("FAIL rd5_rsp2: got %0d, required 0", rd_outstanding);
        end
        rd_rsp(5); expect_err(6, 5); tick();
        rd_req(5, ASE_1CL); tick();
        rd_req(5, ASE_1CL); expect_err(5, 5); tick();
        checks++;
        if (rd_outstanding !== 7'd1) begin
            errors++; $display("FAIL rd5_reuse_kept: got %0d, required 1", rd_outstanding);
        end
        rd_rsp(5); tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        rd_req(3, ASE_1CL); expect_err(9, 3); tick();
        while (!err_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles, required 16", n);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rd_outstanding !== 7'd1) begin
            errors++; $display("FAIL timeout_pending: got %0d, required 1", rd_outstanding);
        end
        rd_rsp(3); tick();
        checks++;
        if (rd_outstanding !== 7'd0) begin
            errors++; $display("FAIL late_rsp_free: got %0d, required 0", rd_outstanding);
        end
    endtask

    task automatic test_almfull();
        c0_almfull = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rd_req(10 + i, ASE_1CL);
            if (i == 8) expect_err(11, 0);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            rd_rsp(10 + i); tick();
        end
        c0_almfull = 1'b0; tick();
        c0_almfull = 1'b1;
        rd_req(20, ASE_1CL); tick();
        rd_rsp(20); tick();
        c0_almfull = 1'b0;
        checks++;
        if (rd_outstanding !== 7'd0) begin
            errors++; $display("FAIL almfull_drain: got %0d, required 0", rd_outstanding);
        end
    endtask

    task automatic test_back_to_back();
        rd_req(40, ASE_1CL); tick();
        rd_rsp(40); rd_req(40, ASE_1CL); tick();
        checks++;
        if (rd_outstanding !== 7'd1) begin
            errors++; $display("FAIL rsp_issue_same_tag: got %0d, required 1", rd_outstanding);
        end
        rd_rsp(40); tick();
        // Two errors in one cycle: lowest code reported, both sticky.
        rd_req(41, ASE_3CL); wr_beat(1'b0, ASE_1CL, 2'd0, 0);
        expect_err(1, 0); exp_sticky[2] = 1'b1; tick();
        checks++;
        if (rd_outstanding !== 7'd0) begin
            errors++; $display("FAIL b2b_drain: got %0d, required 0", rd_outstanding);
        end
    endtask

    task automatic test_illegal_len();
        rd_req(7, ASE_3CL); expect_err(1, 0); tick();
        checks++;
        if (rd_outstanding !== 7'd0) begin
            errors++; $display("FAIL illegal_untracked: got %0d, required 0", rd_outstanding);
        end
        rd_rsp(7); expect_err(6, 7); tick();
    endtask

    task automatic test_sticky();
        tick();
        checks++;
        if (err_sticky !== exp_sticky) begin
            errors++; $display("FAIL sticky: got %h, required %h", err_sticky, exp_sticky);
        end
    endtask

    task automatic test_reset_mid();
        wr_beat(1'b1, ASE_4CL, 2'd0, 50); rd_req(20, ASE_1CL); tick();
        wr_beat(1'b0, ASE_4CL, 2'd0, 50); rd_req(21, ASE_1CL); tick();
        rd_req(22, ASE_1CL); tick();
        checks++;
        if (rd_outstanding !== 7'd3 || wr_outstanding !== 7'd1) begin
            errors++;
            $display("FAIL pre_reset_counts: got rd=%0d wr=%0d, required 3/1", rd_outstanding, wr_outstanding);
        end
        rst_n = 1'b0; exp_sticky = '0;
        #1;
        checks++;
        if (err_valid !== 1'b0 || err_sticky !== 16'h0 || rd_outstanding !== '0 || wr_outstanding !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b sticky=%h rd=%0d wr=%0d, required all 0",
                     err_valid, err_sticky, rd_outstanding, wr_outstanding);
        end
        @(negedge clk); rst_n = 1'b1;
        wr_beat(1'b1, ASE_1CL, 2'd0, 51); tick();
        checks++;
        if (wr_outstanding !== 7'd1) begin
            errors++; $display("FAIL post_reset_sop: got %0d, required 1", wr_outstanding);
        end
        wr_rsp(51, 1'b0); tick();
        checks++;
        if (wr_outstanding !== 7'd0) begin
            errors++; $display("FAIL post_reset_free: got %0d, required 0", wr_outstanding);
        end
    endtask

    initial begin
        clear_inputs();
        c0_almfull = 1'b0;
        c1_almfull = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_4cl();
        test_framing();
        test_read_lifecycle();
        test_timeout();
        test_almfull();
        test_back_to_back();
        test_illegal_len();
        test_sticky();
        test_reset_mid();
        repeat (3) tick();
        checks++;
        if (exp_code_q.size() != 0) begin
            errors++;
            $display("FAIL missing_errs: got %0d unreported, required 0", exp_code_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ccip_protocol_tracker.md
# ccip_protocol_tracker

Cycle-accurate CCI-P protocol tracker that sits beside the AFU port in the ASE (Accelerator Simulation Environment) hardware, in the same position as the existing XZ/reset sniffer.

- **Multi-CL write framing:** validates SOP, length and VC across every C1Tx beat.
- **Read and write tracking:** tracks every outstanding request by mdata tag, and detects tag reuse, orphan responses and response timeouts.
- **Almost-full discipline:** flags requests issued beyond the allowed slack while an almost-full signal is asserted.

Errors are reported as a single registered event stream plus sticky flags. Simulator-side logging consumes these outputs.

## Interface
Parameters:
- TAG_W, 6: number of low mdata bits used as tag; 2^TAG_W entries per table.
- TIMEOUT_CYCLES, 4096: cycles a request may stay pending before a timeout error; must be ≥2.
- AGE_W, 13: age counter width; must satisfy 2^AGE_W > TIMEOUT_CYCLES.
- ALMFULL_SLACK, 8: requests allowed per channel after almost-full rises.

Ports:
- clk  in  1  clock.
- SoftReset_n  in  1  asynchronous, active-low reset.
- C0TxHdr  in  TxHdr_t  read request header.
- C0TxRdValid  in  1  read request valid.
- C1TxHdr  in  TxHdr_t  write request header.
- C1TxWrValid  in  1  write beat valid.
- C0RxHdr  in  RxHdr_t  read response header.
- C0RxRdValid  in  1  read response valid.
- C1RxHdr  in  RxHdr_t  write response header.
- C1RxWrValid  in  1  write response valid.
- C0TxAlmFull  in  1  almost-full for channel 0.
- C1TxAlmFull  in  1  almost-full for channel 1.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  4  ccip_chk_err_e code for the reported error.
- err_tag  out  TAG_W  tag associated with the reported error; 0 for framing and almost-full errors.
- err_sticky  out  16  bit n set once error code n has occurred; never cleared except by reset.
- rd_outstanding  out  TAG_W+1  number of pending read tags.
- wr_outstanding  out  TAG_W+1  number of pending write tags.

## Operation
- **Reset:** all outputs, tables, counters and FSM state go to 0/IDLE.
- **Length encoding:** len 0 = 1CL, 1 = 2CL, 2 = 3CL (illegal), 3 = 4CL. Beat count is len+1.

Write framing FSM (C1Tx):
- IDLE state:
  - A beat with sop=1 and legal len captures len and vc and sets beats_left = len.
  - Go to IN_PKT if beats_left ≠ 0; otherwise stay in IDLE.
  - A beat with sop=0 raises SOP_MISSING (2). The beat is treated as a 1CL packet.
- IN_PKT state:
  - A beat with sop=1 raises SOP_UNEXPECTED (3). The FSM restarts the packet from that beat.
  - A beat whose len or vc differs from the captured values raises HDR_CHANGED (4).
  - Every beat decrements beats_left; the FSM returns to IDLE when it reaches 0.
- A write tag is allocated on the SOP beat only.

Illegal length:
- len=2 on either channel raises ILLEGAL_LEN (1).
- The offending request is not tracked.

Tag tables (rd and wr, identical):
- Each entry holds pending, remaining (2b), age (AGE_W) and timed_out.
- Issue on a free entry: set pending, remaining = len, age = 0.
- Issue on a pending entry raises RD_TAG_REUSE (5) or WR_TAG_REUSE (7). The entry is left unchanged.
- Read response handling:
  - Each response decrements remaining.
  - When a response arrives with remaining = 0, the entry is freed.
- Write response handling:
  - format=1 (packed) frees the entry regardless of remaining.
  - Otherwise the response is handled like a read response.
- A response to a non-pending tag raises RD_ORPHAN_RSP (6) or WR_ORPHAN_RSP (8).
- Pending entries with timed_out=0 increment age every cycle.
  - At age == TIMEOUT_CYCLES−1, raise RD_TIMEOUT (9) or WR_TIMEOUT (10) once and set timed_out.
  - A later response to a timed-out entry is accepted silently.

Almost-full tracking (per channel):
- A counter resets to 0 whenever AlmFull=0.
- While AlmFull=1, the counter increments on each new request; for channel 1, only SOP beats count.
- A request that pushes the counter above ALMFULL_SLACK raises ALMFULL_OVERRUN (11). The counter saturates.

## Timing
- Errors are registered: err_valid asserts in the cycle after the offending clk edge.
- err_code and err_tag are valid only while err_valid=1.
- Multiple errors in one cycle:
  - All corresponding sticky bits set.
  - The lowest code is reported on err_code/err_tag. The others are not queued.
- Response and issue on the same tag in the same cycle: the response is applied first. If it frees the entry, the issue is accepted.
- Outstanding counts update one cycle after the event. A simultaneous alloc and free leaves the count unchanged.
- Asserting SoftReset_n low mid-packet or with tags pending clears everything immediately. No errors are emitted for abandoned state.

## Structure
- ase_pkg gains:
  - ccip_chk_err_e enum (codes 0–11, 0 = NONE).
  - ASE_1CL..ASE_4CL length constants, if not already present.
- Sub-module ccip_tag_tracker:
  - Parametrised by TAG_W, AGE_W and TIMEOUT_CYCLES, with a packed-format enable.
  - Instantiated twice: rd and wr.
  - Outputs per-cycle reuse, orphan and timeout flags with the associated tag, plus its count.
- The top level contains the framing FSM, the almost-full counters, error priority and the sticky register.

## Test plan
- **4CL write framing:** beats with sop 1,0,0,0, len=3 -> no error; wr_outstanding becomes 1. A packed response (format=1) then returns it to 0.
- **Framing violations:**
  - Beat with sop=0 in IDLE -> err_code=2.
  - 2CL packet whose second beat has sop=1 -> err_code=3.
  - 2CL packet whose second beat changes vc -> err_code=4.
- **Read tag lifecycle:**
  - Read tag 5 with len=1, then two responses -> rd_outstanding goes 1→0.
  - A third response -> err_code=6, err_tag=5.
  - Reissue of tag 5 while pending -> err_code=5.
- **Timeout:** with TIMEOUT_CYCLES=16, an unanswered read on tag 3 -> exactly one err_code=9, err_tag=3, 16 cycles after issue. A late response raises no error.
- **Almost-full overrun:** C0TxAlmFull=1 with 9 reads issued -> err_code=11 on the 9th read only; dropping AlmFull resets the counter.
- **Reset mid-operation and illegal length:**
  - Reset during IN_PKT with 4 tags pending -> all outputs 0. A following sop=1 beat is accepted.
  - len=2 read -> err_code=1, request not tracked.
